// File: rtl/video_pkg.sv
// Shared video timing defaults, total-period derivation and pixel/index types
// for the palette scanout path.
package video_pkg;

    localparam int H_ACTIVE_DEF       = 640;
    localparam int H_FP_DEF           = 16;
    localparam int H_SYNC_DEF         = 96;
    localparam int H_BP_DEF           = 48;
    localparam int V_ACTIVE_DEF       = 480;
    localparam int V_FP_DEF           = 10;
    localparam int V_SYNC_DEF         = 2;
    localparam int V_BP_DEF           = 33;
    localparam int PALETTE_LENGTH_DEF = 256;
    localparam int COLOR_BITS_DEF     = 16;
    localparam int FB_LATENCY_DEF     = 1;
    localparam int FB_ADDR_BITS_DEF   = 19;

    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = timing_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = timing_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    typedef logic [COLOR_BITS_DEF-1:0]              color_t;
    typedef logic [$clog2(PALETTE_LENGTH_DEF)-1:0]  index_t;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with async active-low clear; used to align
// timing flags with the palette lookup result.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/palette_scanout.sv
// Raster timing generator feeding a framebuffer -> palette lookup chain;
// sync/active/frame flags are delayed to line up with the registered color.
module palette_scanout
    import video_pkg::*;
#(
    parameter int H_ACTIVE       = H_ACTIVE_DEF,
    parameter int H_FP           = H_FP_DEF,
    parameter int H_SYNC         = H_SYNC_DEF,
    parameter int H_BP           = H_BP_DEF,
    parameter int V_ACTIVE       = V_ACTIVE_DEF,
    parameter int V_FP           = V_FP_DEF,
    parameter int V_SYNC         = V_SYNC_DEF,
    parameter int V_BP           = V_BP_DEF,
    parameter bit SYNC_POL       = 1'b0,
    parameter int PALETTE_LENGTH = PALETTE_LENGTH_DEF,
    parameter int COLOR_BITS     = COLOR_BITS_DEF,
    parameter int FB_LATENCY     = FB_LATENCY_DEF,
    parameter int FB_ADDR_BITS   = FB_ADDR_BITS_DEF
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              enable,
    output logic                              fb_rd_en,
    output logic [FB_ADDR_BITS-1:0]           fb_rd_addr,
    input  logic [$clog2(PALETTE_LENGTH)-1:0] fb_rd_data,
    output logic                              pal_rd_en,
    output logic [$clog2(PALETTE_LENGTH)-1:0] pal_rd_index,
    input  logic [COLOR_BITS-1:0]             pal_rd_color,
    output logic [COLOR_BITS-1:0]             vid_color,
    output logic                              vid_hsync,
    output logic                              vid_vsync,
    output logic                              vid_active,
    output logic                              frame_start
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int L       = FB_LATENCY + 2;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0]           h_q, h_d;
    logic [VW-1:0]           v_q, v_d;
    logic [FB_ADDR_BITS-1:0] addr_q, addr_d;
    logic [FB_LATENCY:0]     act_sr_q;
    logic [COLOR_BITS-1:0]   color_q;
    logic run, h_wrap, v_wrap, act0, hs0, vs0, fs0;
    logic act_l, hs_l, vs_l, fs_l;

    // Stage-0 flags are combinational so scanout starts in the very cycle enable
    // rises; qualifying with reset_n keeps the read strobe quiet during reset.
    assign run    = enable & reset_n;
    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);
    assign act0   = run && (h_q < H_VIS) && (v_q < V_VIS);
    assign hs0    = run && (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs0    = run && (v_q >= VS_BEG) && (v_q < VS_END);
    assign fs0    = act0 && (h_q == '0) && (v_q == '0);

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        addr_d = addr_q;
        if (!enable) begin
            h_d    = '0;
            v_d    = '0;
            addr_d = '0;
        end else begin
            h_d = h_wrap ? '0 : h_q + HW'(1);
            if (h_wrap) v_d = v_wrap ? '0 : v_q + VW'(1);
            if (h_wrap && v_wrap) addr_d = '0;
            else if (act0)        addr_d = addr_q + FB_ADDR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q      <= '0;
            v_q      <= '0;
            addr_q   <= '0;
            act_sr_q <= '0;
            color_q  <= '0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            addr_q   <= addr_d;
            act_sr_q <= {act_sr_q[FB_LATENCY-1:0], act0};
            color_q  <= act_sr_q[FB_LATENCY] ? pal_rd_color : '0;
        end
    end

    pipe_delay #(
        .WIDTH (4),
        .DEPTH (L)
    ) u_align (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .data_i  ({act0, hs0, vs0, fs0}),
        .data_o  ({act_l, hs_l, vs_l, fs_l})
    );

    assign fb_rd_en     = act0;
    assign fb_rd_addr   = addr_q;
    assign pal_rd_index = fb_rd_data;
    assign pal_rd_en    = act_sr_q[FB_LATENCY-1];
    assign vid_color    = color_q;
    assign vid_active   = act_l;
    assign vid_hsync    = hs_l ? SYNC_POL : ~SYNC_POL;
    assign vid_vsync    = vs_l ? SYNC_POL : ~SYNC_POL;
    assign frame_start  = fs_l;

endmodule

// File: doc/palette_scanout.md
PALETTE_SCANOUT -- requirements
Module: palette_scanout

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE 640: visible pixels per line
- H_FP 16: horizontal front porch
- H_SYNC 96: hsync width
- H_BP 48: horizontal back porch
- V_ACTIVE 480: visible lines
- V_FP 10: vertical front porch
- V_SYNC 2: vsync width
- V_BP 33: vertical back porch
- SYNC_POL 0: asserted sync level
- PALETTE_LENGTH 256: palette entries
- COLOR_BITS 16: color width
- FB_LATENCY 1: framebuffer read latency, cycles
- FB_ADDR_BITS 19: framebuffer address width
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  scanout run
- fb_rd_en  out  1  framebuffer read strobe
- fb_rd_addr  out  FB_ADDR_BITS  framebuffer index-byte address
- fb_rd_data  in  $clog2(PALETTE_LENGTH)  palette index, valid FB_LATENCY cycles after strobe
- pal_rd_en  out  1  palette read strobe
- pal_rd_index  out  $clog2(PALETTE_LENGTH)  palette index
- pal_rd_color  in  COLOR_BITS  palette color, valid 1 cycle after index
- vid_color  out  COLOR_BITS  output pixel
- vid_hsync  out  1  horizontal sync
- vid_vsync  out  1  vertical sync
- vid_active  out  1  visible-region flag
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0) at the output

Function
REQ-003 Horizontal counter h SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the horizontal parameters) and wrap to 0; v SHALL increment on h wrap and wrap to 0 after V_TOTAL-1.
REQ-004 Stage-0 active SHALL be (h < H_ACTIVE) and (v < V_ACTIVE); hsync SHALL be asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync likewise on v.
REQ-005 fb_rd_en SHALL equal stage-0 active.
REQ-006 fb_rd_addr SHALL be a running counter: 0 at (0,0), +1 per active pixel, reset to 0 at frame wrap; no multiplier.
REQ-007 pal_rd_index SHALL be fb_rd_data passed through combinationally; pal_rd_en SHALL be stage-0 active delayed by FB_LATENCY.
REQ-008 vid_color SHALL be registered: pal_rd_color when the delayed active is 1, else 0.
REQ-009 Total pipeline latency L = FB_LATENCY+2 cycles; active, hsync, vsync and frame_start SHALL be delayed by exactly L so all outputs align with vid_color.
REQ-010 Sync outputs SHALL equal SYNC_POL when asserted and ~SYNC_POL otherwise.
REQ-011 When enable is low, counters and address SHALL be held at 0 and stage-0 active/sync SHALL be forced inactive. When enable rises, the first frame_start SHALL appear at the outputs L cycles later.
REQ-012 Clearing enable mid-frame SHALL drain the pipeline: in-flight pixels SHALL complete, then outputs SHALL go blank.
REQ-013 The last active pixel (H_ACTIVE-1, V_ACTIVE-1) SHALL read address H_ACTIVE*V_ACTIVE-1; the next active read SHALL be address 0.

Reset
REQ-014 While reset_n is low, all counters and delay stages SHALL be 0 and outputs SHALL be: vid_color 0, vid_active 0, syncs ~SYNC_POL, frame_start 0, fb_rd_en 0, pal_rd_en 0.
REQ-015 Reset SHALL assert asynchronously; the first post-reset scan SHALL start at (0,0) on the first enabled clock after deassertion.

Structure
REQ-016 Package video_pkg SHALL hold the timing-parameter defaults, the H_TOTAL and V_TOTAL derivation, and the color_t and index_t typedefs.
REQ-017 Alignment SHALL use one sub-module, pipe_delay (parameterised width and depth, with async active-low reset), instantiated once for the bundled active, hsync, vsync and frame_start signals.

Verification
REQ-018 The bench SHALL use small timing (H 4/1/1/1, V 3/1/1/1, FB_LATENCY 1). Scenario: the framebuffer model returns data = addr, and the palette model returns color = index+16'h100 -> vid_color sequence 0x100..0x10B over 12 active pixels, then 0 during blanking.
REQ-019 Scenario: count cycles from frame_start to the first vid_active=1 and from fb_rd_en to vid_active -> exactly 0 and L=3 cycles respectively.
REQ-020 Scenario: observe vid_hsync over 3 frames -> one 1-cycle low pulse per 7-cycle line, starting at output h=5; vid_vsync low for one full line per 6-line frame.
REQ-021 Scenario: drop enable at pixel (2,1) -> the 3 in-flight pixels emerge, then vid_active stays 0 and fb_rd_addr stays 0. Re-raise enable -> frame_start 3 cycles later.
REQ-022 Scenario: assert reset_n=0 asynchronously mid-line -> outputs take reset values before the next clk edge; after release with enable=1, the address sequence restarts at 0.
REQ-023 Scenario: run frame wrap with FB_LATENCY=2 -> the address after 11 is 0, and the alignment of vid_color to vid_active is preserved (L=4).
